// File: rtl/clk_burst_divider.sv
// Multi-channel programmable clock divider with free-running, burst and single-step modes.
// Every output is registered; each channel has its own IDLE/RUN controller.
module clk_burst_divider #(
    parameter int CHANNELS           = 2,
    parameter int COUNTER_BITS       = 32,
    parameter int PULSE_CONTROL_BITS = 32,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [CH_W-1:0]               cfg_ch,
    input  logic [1:0]                    cfg_mode,
    input  logic [COUNTER_BITS-1:0]       cfg_divider,
    input  logic [PULSE_CONTROL_BITS-1:0] cfg_pulses,
    input  logic [CHANNELS-1:0]           start,
    input  logic [CHANNELS-1:0]           stop,
    input  logic                          out_enable,
    output logic [CHANNELS-1:0]           clk_en_o,
    output logic [CHANNELS-1:0]           clk_o,
    output logic [CHANNELS-1:0]           busy,
    output logic [CHANNELS-1:0]           done
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_STEP  = 2'b11;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // A divider of zero behaves like one: tick every enabled cycle.
    function automatic logic [COUNTER_BITS-1:0] eff_div(input logic [COUNTER_BITS-1:0] d);
        return (d == '0) ? COUNTER_BITS'(1) : d;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]                    mode_q;
        logic [COUNTER_BITS-1:0]       div_q;
        logic [PULSE_CONTROL_BITS-1:0] pulses_q;
        logic [COUNTER_BITS-1:0]       div_act;
        logic [COUNTER_BITS-1:0]       cnt;
        logic [PULSE_CONTROL_BITS-1:0] target;
        logic [PULSE_CONTROL_BITS-1:0] ticks;
        logic                          run_burst;
        logic                          phase;
        logic                          en_q;
        logic                          clk_q;
        logic                          done_q;
        state_t                        state;
        state_t                        state_nxt;

        logic                          wr_hit;
        logic                          abort;
        logic                          start_ok;
        logic                          start_burst;
        logic [PULSE_CONTROL_BITS-1:0] start_tgt;
        logic                          zero_burst;
        logic                          finish;
        logic                          advance;
        logic                          tick;
        logic                          phase_nxt;

        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q   <= MODE_OFF;
                div_q    <= COUNTER_BITS'(1);
                pulses_q <= '0;
            end else if (wr_hit) begin
                mode_q   <= cfg_mode;
                div_q    <= cfg_divider;
                pulses_q <= cfg_pulses;
            end
        end

        // Abort (stop or a write turning the channel off) outranks start, completion and ticks.
        always_comb begin
            start_burst = (mode_q == MODE_BURST) || (mode_q == MODE_STEP);
            start_tgt   = (mode_q == MODE_STEP) ? PULSE_CONTROL_BITS'(1) : pulses_q;
            abort       = stop[i] || (wr_hit && (cfg_mode == MODE_OFF));
            start_ok    = start[i] && (mode_q != MODE_OFF) && !abort;
            zero_burst  = (state == IDLE) && start_ok && start_burst && (start_tgt == '0);
            finish      = (state == RUN) && !abort && run_burst && (ticks == target);
            advance     = (state == RUN) && !abort && !finish && out_enable;
            tick        = advance && (cnt == div_act - COUNTER_BITS'(1));
            phase_nxt   = tick ? ~phase : phase;
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (start_ok && !zero_burst) state_nxt = RUN;
                RUN:     if (abort || finish) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) state <= IDLE;
            else     state <= state_nxt;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt       <= '0;
                ticks     <= '0;
                target    <= '0;
                div_act   <= COUNTER_BITS'(1);
                run_burst <= 1'b0;
                phase     <= 1'b0;
                en_q      <= 1'b0;
                clk_q     <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                en_q   <= tick;
                done_q <= zero_burst || finish;
                clk_q  <= (state_nxt == RUN) && out_enable && phase_nxt;
                if ((state == IDLE) && (state_nxt == RUN)) begin
                    cnt       <= '0;
                    ticks     <= '0;
                    phase     <= 1'b0;
                    div_act   <= eff_div(div_q);
                    target    <= start_tgt;
                    run_burst <= start_burst;
                end else if (state_nxt == IDLE) begin
                    cnt   <= '0;
                    ticks <= '0;
                    phase <= 1'b0;
                end else if (tick) begin
                    // Wrap point: a divider written mid-run is picked up here.
                    cnt     <= '0;
                    ticks   <= ticks + PULSE_CONTROL_BITS'(1);
                    phase   <= ~phase;
                    div_act <= eff_div(div_q);
                end else if (advance) begin
                    cnt <= cnt + COUNTER_BITS'(1);
                end
            end
        end

        assign clk_en_o[i] = en_q;
        assign clk_o[i]    = clk_q;
        assign busy[i]     = (state == RUN);
        assign done[i]     = done_q;
    end

endmodule

// File: tb/tb_clk_burst_divider.sv
// Randomized and directed bench for clk_burst_divider, checked every cycle against a
// countdown-style behavioural model plus literal expectations for the key scenarios.
module tb_clk_burst_divider;

    localparam int NCH = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = 2'd0;
    logic [1:0]     cfg_mode = 2'd0;
    logic [7:0]     cfg_divider = 8'd0;
    logic [7:0]     cfg_pulses = 8'd0;
    logic [NCH-1:0] start = '0;
    logic [NCH-1:0] stop = '0;
    logic           out_enable = 1'b1;
    logic [NCH-1:0] clk_en_o;
    logic [NCH-1:0] clk_o;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;

    int vectors = 0;
    int miscompares = 0;

    clk_burst_divider #(
        .CHANNELS(NCH),
        .COUNTER_BITS(8),
        .PULSE_CONTROL_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_divider(cfg_divider),
        .cfg_pulses(cfg_pulses),
        .start(start),
        .stop(stop),
        .out_enable(out_enable),
        .clk_en_o(clk_en_o),
        .clk_o(clk_o),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per channel, count remaining ticks down and cycles-to-next-tick down.
    int m_mode[NCH], m_div[NCH], m_pul[NCH];
    bit run[NCH], bur[NCH], ph[NCH];
    int left[NCH], wait_c[NCH];
    logic [NCH-1:0] e_en = '0, e_clk = '0, e_busy = '0, e_done = '0;
    bit m_wr, m_ab;
    int m_tgt;

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_mode[c] = 0; m_div[c] = 1; m_pul[c] = 0;
                run[c] = 0; bur[c] = 0; ph[c] = 0; left[c] = 0; wait_c[c] = 0;
                e_en[c] = 0; e_clk[c] = 0; e_busy[c] = 0; e_done[c] = 0;
            end else begin
                m_wr = cfg_we && (int'(cfg_ch) == c);
                m_ab = stop[c] || (m_wr && cfg_mode == 2'b00);
                e_en[c] = 0;
                e_done[c] = 0;
                if (run[c]) begin
                    if (m_ab) run[c] = 0;
                    else if (bur[c] && left[c] == 0) begin
                        run[c] = 0;
                        e_done[c] = 1;
                    end else if (out_enable) begin
                        wait_c[c]--;
                        if (wait_c[c] == 0) begin
                            e_en[c] = 1;
                            ph[c] = !ph[c];
                            wait_c[c] = (m_div[c] == 0) ? 1 : m_div[c];
                            if (bur[c]) left[c]--;
                        end
                    end
                end else if (!m_ab && start[c] && m_mode[c] != 0) begin
                    m_tgt = (m_mode[c] == 3) ? 1 : m_pul[c];
                    if (m_mode[c] >= 2 && m_tgt == 0) e_done[c] = 1;
                    else begin
                        run[c] = 1;
                        bur[c] = (m_mode[c] >= 2);
                        left[c] = m_tgt;
                        wait_c[c] = (m_div[c] == 0) ? 1 : m_div[c];
                        ph[c] = 0;
                    end
                end
                if (m_wr) begin
                    m_mode[c] = int'(cfg_mode);
                    m_div[c] = int'(cfg_divider);
                    m_pul[c] = int'(cfg_pulses);
                end
                e_busy[c] = run[c];
                e_clk[c] = run[c] && out_enable && ph[c];
            end
        end
    end

    always @(negedge clk) begin
        chk("model_clk_en_o", 32'(clk_en_o), 32'(e_en));
        chk("model_clk_o", 32'(clk_o), 32'(e_clk));
        chk("model_busy", 32'(busy), 32'(e_busy));
        chk("model_done", 32'(done), 32'(e_done));
    end

    task automatic cfg_write(input int ch, input logic [1:0] md, input int dv, input int pl);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_mode = md;
        cfg_divider = 8'(dv);
        cfg_pulses = 8'(pl);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic kick(input logic [NCH-1:0] m);
        start = m;
        @(negedge clk);
        start = '0;
    endtask

    task automatic halt(input logic [NCH-1:0] m);
        stop = m;
        @(negedge clk);
        stop = '0;
    endtask

    int nt, first, last, nd, dk, lowt;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {clk_en_o, clk_o, busy, done}, 0);
        rst = 1'b0;

        // FREE, divider 4
        cfg_write(0, 2'b01, 4, 0);
        kick(3'b001);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("free4_en", clk_en_o[0], (k % 4 == 0));
            chk("free4_clk", clk_o[0], ((k / 4) % 2 == 1));
            chk("free4_done", done[0], 0);
        end
        halt(3'b001);

        // BURST, divider 3, 5 pulses
        cfg_write(0, 2'b10, 3, 5);
        kick(3'b001);
        nt = 0; first = -1; last = -1; nd = 0; dk = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (clk_en_o[0]) begin
                nt++;
                if (first < 0) first = k;
                last = k;
            end
            if (done[0]) begin nd++; dk = k; end
            if (k == 15) chk("burst_busy_k15", busy[0], 1);
            if (k == 16) chk("burst_busy_k16", busy[0], 0);
        end
        chk("burst_ticks", nt, 5);
        chk("burst_first", first, 3);
        chk("burst_last", last, 15);
        chk("burst_dones", nd, 1);
        chk("burst_done_cycle", dk, 16);
        chk("burst_clk_after", clk_o[0], 0);

        // BURST with zero pulses and zero divider
        cfg_write(0, 2'b10, 0, 0);
        kick(3'b001);
        chk("zero_done", done[0], 1);
        chk("zero_busy", busy[0], 0);
        chk("zero_en", clk_en_o[0], 0);
        @(negedge clk);
        chk("zero_done_once", done[0], 0);

        // FREE with zero divider
        cfg_write(0, 2'b01, 0, 0);
        kick(3'b001);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("div0_en", clk_en_o[0], 1);
            chk("div0_clk", clk_o[0], k % 2);
        end
        halt(3'b001);

        // stop+start on ch1 mid-burst while ch0 free-runs
        cfg_write(0, 2'b01, 3, 0);
        cfg_write(1, 2'b10, 2, 8);
        kick(3'b011);
        nd = 0;
        for (int k = 1; k <= 20; k++) begin
            stop = (k == 6) ? 3'b010 : 3'b000;
            start = (k == 6) ? 3'b010 : 3'b000;
            @(negedge clk);
            chk("free3_spacing", clk_en_o[0], (k % 3 == 0));
            if (k >= 6) chk("abort_busy1", busy[1], 0);
            if (done[1]) nd++;
        end
        stop = '0; start = '0;
        chk("abort_no_done", nd, 0);
        halt(3'b001);

        // out_enable low for 10 cycles in a 4-pulse burst
        cfg_write(0, 2'b10, 2, 4);
        kick(3'b001);
        nt = 0; lowt = 0; nd = 0;
        for (int k = 1; k <= 30; k++) begin
            out_enable = !(k >= 4 && k <= 13);
            @(negedge clk);
            if (clk_en_o[0]) nt++;
            if (!out_enable && (clk_en_o[0] || clk_o[0])) lowt++;
            if (done[0]) nd++;
        end
        out_enable = 1'b1;
        chk("gate_low_activity", lowt, 0);
        chk("gate_total_ticks", nt, 4);
        chk("gate_dones", nd, 1);

        // out-of-range channel write ignored
        cfg_write(3, 2'b01, 2, 0);
        kick(3'b100);
        chk("bad_ch_busy2", busy[2], 0);

        // reset mid-burst
        cfg_write(0, 2'b10, 2, 5);
        kick(3'b001);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {clk_en_o, clk_o, busy, done}, 0);
        rst = 1'b0;
        kick(3'b001);
        chk("rst_off_busy", busy[0], 0);
        @(negedge clk);
        chk("rst_off_busy2", busy[0], 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cfg_we = ($urandom_range(7) == 0);
            cfg_ch = 2'($urandom_range(3));
            cfg_mode = 2'($urandom_range(3));
            cfg_divider = 8'($urandom_range(5));
            cfg_pulses = 8'($urandom_range(6));
            for (int c = 0; c < NCH; c++) begin
                start[c] = ($urandom_range(3) == 0);
                stop[c] = ($urandom_range(15) == 0);
            end
            out_enable = ($urandom_range(7) != 0);
            rst = ($urandom_range(199) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cfg_we = 1'b0; start = '0; stop = '0; out_enable = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
